// File: rtl/kvaz_multi_if.sv
// CPU-side bus bundle for the kvaz_multi RAM-disk mapper.
// CHW must match the mapper's channel index width.
interface kvaz_multi_if #(
  parameter int unsigned CHW = 3
) ();
  logic           clke;
  logic           cycle_start;
  logic [7:0]     shavv;
  logic [7:0]     port_addr;
  logic [7:0]     data_in;
  logic           iowr;
  logic           iord;
  logic           memwr;
  logic           stack;
  logic           boot;
  logic [7:0]     data_out;
  logic           data_oe;
  logic [CHW+1:0] bigram_addr;
  logic           blk_n;
  logic           conflict;
  logic [7:0]     debug;

  modport master (
    output clke, cycle_start, shavv, port_addr, data_in, iowr, iord, memwr, stack, boot,
    input  data_out, data_oe, bigram_addr, blk_n, conflict, debug
  );

  modport slave (
    input  clke, cycle_start, shavv, port_addr, data_in, iowr, iord, memwr, stack, boot,
    output data_out, data_oe, bigram_addr, blk_n, conflict, debug
  );
endinterface

// File: rtl/kvaz_multi.sv
// Multi-channel RAM-disk memory mapper: decodes each CPU memory cycle against
// per-channel control registers and latches an SDRAM bank {channel, page}.
module kvaz_multi #(
  parameter int unsigned    NCH         = 8,
  parameter logic [7:0]     BASE_PORT   = 8'h10,
  parameter logic [7:0]     STATUS_PORT = 8'h1F,
  parameter bit             BARKAR      = 1'b1,
  parameter int unsigned    CHW         = (NCH > 1) ? $clog2(NCH) : 1,
  parameter logic [CHW+1:0] BOOT_BANK   = {(CHW + 2){1'b1}}
) (
  input logic           clk,
  input logic           reset,
  kvaz_multi_if.slave   bus
);

  typedef enum logic [1:0] {BootOn = 2'b01, BootOff = 2'b10} boot_e;

  logic [7:0]     cr_q [NCH];
  logic [7:0]     cr_d [NCH];
  logic [CHW+1:0] bigram_q, bigram_d;
  logic           blk_n_q, blk_n_d;
  logic           hit_q, hit_d;
  logic [CHW-1:0] last_ch_q, last_ch_d;
  logic           conflict_q, conflict_d;
  logic [7:0]     data_out_q, data_out_d;
  logic           data_oe_q, data_oe_d;
  boot_e          boot_q, boot_d;

  logic [3:0]     nib;
  logic [NCH-1:0] win_hit, stack_hit, claim;
  logic           any_claim, multi_claim, boot_hit, status_rd, found;
  logic [CHW-1:0] win_ch;
  logic [1:0]     win_page;
  logic           unused_shavv;

  assign nib          = bus.shavv[7:4];
  assign unused_shavv = ^bus.shavv[3:0];

  // Per-channel claim and lowest-numbered-winner arbitration
  always_comb begin
    win_hit   = '0;
    stack_hit = '0;
    claim     = '0;
    found     = 1'b0;
    win_ch    = '0;
    win_page  = '0;
    for (int n = 0; n < NCH; n++) begin
      win_hit[n]   = (nib inside {4'hA, 4'hB, 4'hC, 4'hD})
                   | (BARKAR & cr_q[n][6] & (nib[3:1] == 3'b100))
                   | (BARKAR & cr_q[n][7] & (nib[3:1] == 3'b111));
      stack_hit[n] = cr_q[n][4] & bus.stack;
      claim[n]     = stack_hit[n] | (cr_q[n][5] & win_hit[n]);
    end
    for (int n = 0; n < NCH; n++) begin
      if (claim[n] && !found) begin
        found    = 1'b1;
        win_ch   = CHW'(n);
        win_page = stack_hit[n] ? cr_q[n][3:2] : cr_q[n][1:0];
      end
    end
  end

  assign any_claim   = |claim;
  assign multi_claim = $countones(claim) > 1;
  assign boot_hit    = (boot_q == BootOn) & bus.boot & ~bus.shavv[7] & ~bus.memwr
                     & ~bus.iowr & ~bus.iord;
  assign status_rd   = bus.clke & bus.iord & (bus.port_addr == STATUS_PORT);

  always_comb begin
    cr_d       = cr_q;
    bigram_d   = bigram_q;
    blk_n_d    = blk_n_q;
    hit_d      = hit_q;
    last_ch_d  = last_ch_q;
    conflict_d = conflict_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    boot_d     = boot_q;

    if (bus.clke && bus.iowr) begin
      for (int n = 0; n < NCH; n++) begin
        if (bus.port_addr == BASE_PORT + 8'(n)) cr_d[n] = bus.data_in;
      end
    end

    // Decode uses cr_q, so a same-clk write only shows up at the next cycle_start
    if (bus.cycle_start) begin
      hit_d   = any_claim | boot_hit;
      blk_n_d = ~hit_d;
      if (any_claim) begin
        bigram_d  = {win_ch, win_page};
        last_ch_d = win_ch;
      end else if (boot_hit) begin
        bigram_d = BOOT_BANK;
      end else begin
        bigram_d = '0;
      end
    end

    if (bus.cycle_start && multi_claim) conflict_d = 1'b1;
    else if (status_rd)                 conflict_d = 1'b0;

    if (bus.clke) begin
      data_oe_d = 1'b0;
      if (status_rd) begin
        data_out_d = {conflict_q, boot_q == BootOn, 3'b000, 3'(last_ch_q)};
        data_oe_d  = 1'b1;
      end else if (bus.iord) begin
        for (int n = 0; n < NCH; n++) begin
          if (bus.port_addr == BASE_PORT + 8'(n)) begin
            data_out_d = cr_q[n];
            data_oe_d  = 1'b1;
          end
        end
      end
    end

    case (boot_q)
      BootOn: begin
        if (bus.clke && (!bus.boot || (bus.iowr && bus.port_addr == STATUS_PORT
                                       && bus.data_in == 8'hB0))) begin
          boot_d = BootOff;
        end
      end
      default: boot_d = BootOff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NCH; n++) cr_q[n] <= '0;
      bigram_q   <= '0;
      blk_n_q    <= 1'b1;
      hit_q      <= 1'b0;
      last_ch_q  <= '0;
      conflict_q <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      boot_q     <= BootOn;
    end else begin
      cr_q       <= cr_d;
      bigram_q   <= bigram_d;
      blk_n_q    <= blk_n_d;
      hit_q      <= hit_d;
      last_ch_q  <= last_ch_d;
      conflict_q <= conflict_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      boot_q     <= boot_d;
    end
  end

  assign bus.bigram_addr = bigram_q;
  assign bus.blk_n       = blk_n_q;
  assign bus.conflict    = conflict_q;
  assign bus.data_out    = data_out_q;
  assign bus.data_oe     = data_oe_q;
  assign bus.debug       = {boot_q, hit_q, conflict_q, 4'(last_ch_q)};

endmodule

// File: tb/tb_kvaz_multi.sv
// Bench for kvaz_multi: an 8-channel Barkar instance and a 2-channel plain
// instance share stimulus; directed scenarios plus a random run against a model.
module tb_kvaz_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       clke, cycle_start, iowr, iord, memwr, stack, boot;
  logic [7:0] shavv, port_addr, data_in;

  int n_cmp = 0;
  int n_err = 0;

  kvaz_multi_if #(.CHW(3)) bus0 ();
  kvaz_multi_if #(.CHW(1)) bus1 ();

  assign bus0.clke = clke;            assign bus1.clke = clke;
  assign bus0.cycle_start = cycle_start; assign bus1.cycle_start = cycle_start;
  assign bus0.shavv = shavv;          assign bus1.shavv = shavv;
  assign bus0.port_addr = port_addr;  assign bus1.port_addr = port_addr;
  assign bus0.data_in = data_in;      assign bus1.data_in = data_in;
  assign bus0.iowr = iowr;            assign bus1.iowr = iowr;
  assign bus0.iord = iord;            assign bus1.iord = iord;
  assign bus0.memwr = memwr;          assign bus1.memwr = memwr;
  assign bus0.stack = stack;          assign bus1.stack = stack;
  assign bus0.boot = boot;            assign bus1.boot = boot;

  kvaz_multi #(.NCH(8), .BARKAR(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  kvaz_multi #(.NCH(2), .BARKAR(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  // Reference model, index 0 = 8ch/Barkar, 1 = 2ch/plain
  int m_cr [2][8];
  int m_conf [2], m_boot_on [2], m_last [2], m_bank [2], m_blk [2], m_dout [2], m_oe [2];

  task automatic model_step(input int k);
    int nch, chw, first, cnt, page, nib, crv, conf_old, boot_old, last_old, p;
    bit barkar, sh, w, rh, bh, srd;
    nch = (k == 0) ? 8 : 2;
    chw = (k == 0) ? 3 : 1;
    barkar = (k == 0);
    if (reset) begin
      for (int i = 0; i < 8; i++) m_cr[k][i] = 0;
      m_conf[k] = 0; m_boot_on[k] = 1; m_last[k] = 0; m_bank[k] = 0;
      m_blk[k] = 1; m_dout[k] = 0; m_oe[k] = 0;
      return;
    end
    conf_old = m_conf[k]; boot_old = m_boot_on[k]; last_old = m_last[k];
    first = -1; cnt = 0; page = 0; nib = int'(shavv) / 16;
    for (int n = 0; n < nch; n++) begin
      crv = m_cr[k][n];
      sh = ((crv / 16) % 2 == 1) && stack;
      w  = (nib >= 10 && nib <= 13)
        || (barkar && (crv / 64) % 2 == 1 && (nib == 8 || nib == 9))
        || (barkar && crv >= 128 && nib >= 14);
      rh = ((crv / 32) % 2 == 1) && w;
      if (sh || rh) begin
        cnt++;
        if (first < 0) begin
          first = n;
          page = sh ? (crv / 4) % 4 : crv % 4;
        end
      end
    end
    bh = boot_old == 1 && boot && shavv < 128 && !memwr && !iowr && !iord;
    if (cycle_start) begin
      if (first >= 0) begin
        m_bank[k] = first * 4 + page; m_blk[k] = 0; m_last[k] = first;
      end else if (bh) begin
        m_bank[k] = (1 << (chw + 2)) - 1; m_blk[k] = 0;
      end else begin
        m_bank[k] = 0; m_blk[k] = 1;
      end
    end
    srd = clke && iord && port_addr == 8'h1F;
    if (cycle_start && cnt > 1) m_conf[k] = 1;
    else if (srd) m_conf[k] = 0;
    if (clke) begin
      p = int'(port_addr) - 16;
      if (srd) begin
        m_dout[k] = conf_old * 128 + boot_old * 64 + last_old; m_oe[k] = 1;
      end else if (iord && p >= 0 && p < nch) begin
        m_dout[k] = m_cr[k][p]; m_oe[k] = 1;
      end else begin
        m_oe[k] = 0;
      end
      if (iowr && p >= 0 && p < nch) m_cr[k][p] = int'(data_in);
      if (boot_old == 1 && (!boot || (iowr && port_addr == 8'h1F && data_in == 8'hB0)))
        m_boot_on[k] = 0;
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle_start = 0; clke = 0; iowr = 0; iord = 0; memwr = 0; stack = 0;
  endtask

  task automatic io_out(input logic [7:0] p, input logic [7:0] d);
    port_addr = p; data_in = d; clke = 1; iowr = 1;
    tick();
    clke = 0; iowr = 0;
  endtask

  task automatic io_in(input logic [7:0] p);
    port_addr = p; clke = 1; iord = 1;
    tick();
    clke = 0; iord = 0;
  endtask

  task automatic mem(input logic [7:0] a, input logic stk, input logic wr);
    shavv = a; stack = stk; memwr = wr; cycle_start = 1;
    tick();
    cycle_start = 0; stack = 0; memwr = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    idle(); boot = 1; shavv = 0; port_addr = 0; data_in = 0;
    do_reset();
    n_cmp++;
    if (bus0.blk_n !== 1'b1 || bus0.bigram_addr !== 5'd0 || bus0.conflict !== 1'b0 ||
        bus0.data_oe !== 1'b0 || bus0.data_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset0: blk_n=%b bank=%0d conf=%b oe=%b dout=%h want 1/0/0/0/00",
               bus0.blk_n, bus0.bigram_addr, bus0.conflict, bus0.data_oe, bus0.data_out);
    end
    n_cmp++;
    if (bus1.blk_n !== 1'b1 || bus1.bigram_addr !== 3'd0 || bus1.conflict !== 1'b0) begin
      n_err++;
      $display("FAIL reset1: blk_n=%b bank=%0d conf=%b want 1/0/0",
               bus1.blk_n, bus1.bigram_addr, bus1.conflict);
    end
  endtask

  task automatic test_boot();
    mem(8'h10, 0, 0);
    n_cmp++;
    if (bus0.blk_n !== 1'b0 || bus0.bigram_addr !== 5'd31 ||
        bus1.blk_n !== 1'b0 || bus1.bigram_addr !== 3'd7) begin
      n_err++;
      $display("FAIL boot_hit: blk=%b/%b bank=%0d/%0d want 0/0 31/7",
               bus0.blk_n, bus1.blk_n, bus0.bigram_addr, bus1.bigram_addr);
    end
    io_in(8'h1F);
    n_cmp++;
    if (bus0.data_out !== 8'h40 || bus0.data_oe !== 1'b1) begin
      n_err++;
      $display("FAIL boot_status: dout=%h oe=%b want 40/1", bus0.data_out, bus0.data_oe);
    end
    mem(8'h10, 0, 1);
    n_cmp++;
    if (bus0.blk_n !== 1'b1) begin
      n_err++; $display("FAIL boot_memwr: blk_n=%b want 1", bus0.blk_n);
    end
    boot = 0; clke = 1; tick(); clke = 0; boot = 1;
    mem(8'h10, 0, 0);
    n_cmp++;
    if (bus0.blk_n !== 1'b1 || bus1.blk_n !== 1'b1) begin
      n_err++; $display("FAIL boot_sticky: blk_n=%b/%b want 1/1", bus0.blk_n, bus1.blk_n);
    end
    do_reset();
    io_out(8'h1F, 8'hB0);
    mem(8'h10, 0, 0);
    n_cmp++;
    if (bus0.blk_n !== 1'b1 || bus1.blk_n !== 1'b1) begin
      n_err++; $display("FAIL boot_b0_disarm: blk_n=%b/%b want 1/1", bus0.blk_n, bus1.blk_n);
    end
    boot = 0;
    do_reset();
  endtask

  task automatic test_ram_window();
    io_out(8'h10, 8'h20);
    mem(8'hA5, 0, 0);
    n_cmp++;
    if (bus0.blk_n !== 1'b0 || bus0.bigram_addr !== 5'd0 ||
        bus1.blk_n !== 1'b0 || bus1.bigram_addr !== 3'd0) begin
      n_err++;
      $display("FAIL ram_a5: blk=%b/%b bank=%0d/%0d want 0/0 0/0",
               bus0.blk_n, bus1.blk_n, bus0.bigram_addr, bus1.bigram_addr);
    end
    mem(8'hE0, 0, 0);
    n_cmp++;
    if (bus0.blk_n !== 1'b1 || bus1.blk_n !== 1'b1) begin
      n_err++; $display("FAIL ram_e0: blk_n=%b/%b want 1/1", bus0.blk_n, bus1.blk_n);
    end
  endtask

  task automatic test_stack();
    io_out(8'h13, 8'h1E);
    mem(8'h30, 1, 0);
    n_cmp++;
    if (bus0.blk_n !== 1'b0 || bus0.bigram_addr !== 5'd15 || bus1.blk_n !== 1'b1) begin
      n_err++;
      $display("FAIL stack_hit: blk=%b/%b bank=%0d want 0/1 15",
               bus0.blk_n, bus1.blk_n, bus0.bigram_addr);
    end
    mem(8'h30, 0, 0);
    n_cmp++;
    if (bus0.blk_n !== 1'b1) begin
      n_err++; $display("FAIL stack_off: blk_n=%b want 1", bus0.blk_n);
    end
  endtask

  task automatic test_conflict();
    io_out(8'h11, 8'h21);
    mem(8'hB0, 0, 0);
    n_cmp++;
    if (bus0.bigram_addr !== 5'd0 || bus0.blk_n !== 1'b0 || bus0.conflict !== 1'b1 ||
        bus1.conflict !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_set: bank=%0d blk=%b conf=%b/%b want 0 0 1/1",
               bus0.bigram_addr, bus0.blk_n, bus0.conflict, bus1.conflict);
    end
    io_in(8'h1F);
    n_cmp++;
    if (bus0.data_out !== 8'h80 || bus0.conflict !== 1'b0 || bus1.conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_clear: dout=%h conf=%b/%b want 80 0/0",
               bus0.data_out, bus0.conflict, bus1.conflict);
    end
  endtask

  task automatic test_barkar();
    io_out(8'h12, 8'h60);
    mem(8'h85, 0, 0);
    n_cmp++;
    if (bus0.blk_n !== 1'b0 || bus0.bigram_addr !== 5'd8 || bus1.blk_n !== 1'b1) begin
      n_err++;
      $display("FAIL barkar_ch2: blk=%b/%b bank=%0d want 0/1 8",
               bus0.blk_n, bus1.blk_n, bus0.bigram_addr);
    end
    io_out(8'h10, 8'h60);
    mem(8'h85, 0, 0);
    n_cmp++;
    if (bus0.bigram_addr !== 5'd0 || bus0.blk_n !== 1'b0 || bus1.blk_n !== 1'b1) begin
      n_err++;
      $display("FAIL barkar_off: blk=%b/%b bank=%0d want 0/1 0",
               bus0.blk_n, bus1.blk_n, bus0.bigram_addr);
    end
  endtask

  task automatic test_latch();
    io_out(8'h10, 8'h20);
    port_addr = 8'h10; data_in = 8'h21; clke = 1; iowr = 1;
    shavv = 8'hC0; cycle_start = 1;
    tick();
    idle();
    n_cmp++;
    if (bus0.bigram_addr !== 5'd0 || bus1.bigram_addr !== 3'd0) begin
      n_err++;
      $display("FAIL latch_old: bank=%0d/%0d want 0/0", bus0.bigram_addr, bus1.bigram_addr);
    end
    mem(8'hC0, 0, 0);
    n_cmp++;
    if (bus0.bigram_addr !== 5'd1 || bus1.bigram_addr !== 3'd1) begin
      n_err++;
      $display("FAIL latch_new: bank=%0d/%0d want 1/1", bus0.bigram_addr, bus1.bigram_addr);
    end
  endtask

  task automatic test_readback();
    logic [7:0] d;
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      io_out(8'(8'h10 + n), d);
      io_in(8'(8'h10 + n));
      n_cmp++;
      if (bus0.data_out !== d || bus0.data_oe !== 1'b1 || bus1.data_oe !== (n < 2)) begin
        n_err++;
        $display("FAIL readback_%0d: dout=%h oe=%b/%b want %h 1/%b",
                 n, bus0.data_out, bus0.data_oe, bus1.data_oe, d, n < 2);
      end
    end
    clke = 1; tick(); clke = 0;
    n_cmp++;
    if (bus0.data_oe !== 1'b0 || bus1.data_oe !== 1'b0) begin
      n_err++; $display("FAIL oe_drop: oe=%b/%b want 0/0", bus0.data_oe, bus1.data_oe);
    end
    io_in(8'h05);
    n_cmp++;
    if (bus0.data_oe !== 1'b0) begin
      n_err++; $display("FAIL other_port: oe=%b want 0", bus0.data_oe);
    end
  endtask

  task automatic test_random();
    int r, op;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      cycle_start = ($urandom_range(0, 2) == 0);
      clke = $urandom_range(0, 1) == 1;
      op = $urandom_range(0, 3);
      iowr = (op == 1); iord = (op == 2);
      memwr = ($urandom_range(0, 3) == 0);
      stack = ($urandom_range(0, 3) == 0);
      boot = ($urandom_range(0, 4) != 0);
      shavv = 8'($urandom);
      r = $urandom_range(0, 9);
      port_addr = (r < 8) ? 8'(16 + r) : (r == 8) ? 8'h1F : 8'($urandom);
      data_in = ($urandom_range(0, 7) == 0) ? 8'hB0 : 8'($urandom);
      tick();
      n_cmp++;
      if (bus0.blk_n !== 1'(m_blk[0]) || bus0.bigram_addr !== 5'(m_bank[0]) ||
          bus0.conflict !== 1'(m_conf[0]) || bus0.data_oe !== 1'(m_oe[0]) ||
          bus0.data_out !== 8'(m_dout[0])) begin
        n_err++;
        $display("FAIL rand0 #%0d: blk=%b bank=%0d conf=%b oe=%b dout=%h want %0d %0d %0d %0d %h",
                 i, bus0.blk_n, bus0.bigram_addr, bus0.conflict, bus0.data_oe, bus0.data_out,
                 m_blk[0], m_bank[0], m_conf[0], m_oe[0], m_dout[0]);
      end
      n_cmp++;
      if (bus1.blk_n !== 1'(m_blk[1]) || bus1.bigram_addr !== 3'(m_bank[1]) ||
          bus1.conflict !== 1'(m_conf[1]) || bus1.data_oe !== 1'(m_oe[1]) ||
          bus1.data_out !== 8'(m_dout[1])) begin
        n_err++;
        $display("FAIL rand1 #%0d: blk=%b bank=%0d conf=%b oe=%b dout=%h want %0d %0d %0d %0d %h",
                 i, bus1.blk_n, bus1.bigram_addr, bus1.conflict, bus1.data_oe, bus1.data_out,
                 m_blk[1], m_bank[1], m_conf[1], m_oe[1], m_dout[1]);
      end
    end
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    boot = 1; shavv = 0; port_addr = 0; data_in = 0;
    #1;
    test_reset();
    test_boot();
    test_ram_window();
    test_stack();
    test_conflict();
    test_barkar();
    test_latch();
    test_readback();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
